// File: rtl/blinker_nios2_proc_ocimem_arbiter_pkg.sv
// Shared definitions for the OCI debug-memory arbiter: FSM encoding,
// grant identifiers and the legal RAM latency range.
package blinker_nios2_proc_ocimem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic GRANT_JTAG = 1'b0;
  localparam logic GRANT_AVS  = 1'b1;

  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 3;

  function automatic bit ram_lat_ok(input int lat);
    return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
  endfunction

endpackage

// File: rtl/blinker_nios2_proc_ocimem_rr2.sv
// Two-way round-robin picker; on a tie the requester that was not served
// last wins. Purely combinational, history is held by the caller.
module blinker_nios2_proc_ocimem_rr2
  import blinker_nios2_proc_ocimem_arbiter_pkg::*;
(
  input  logic [1:0] req,          // [0] JTAG, [1] Avalon
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant       = GRANT_JTAG;
    case (req)
      2'b01:   grant = GRANT_JTAG;
      2'b10:   grant = GRANT_AVS;
      2'b11:   grant = (last_grant == GRANT_AVS) ? GRANT_JTAG : GRANT_AVS;
      default: grant = GRANT_JTAG;
    endcase
  end

endmodule

// File: rtl/blinker_nios2_proc_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG command path and the
// CPU-side Avalon debug slave, one access at a time.
//
//   state | meaning
//   IDLE  | no access in flight; pick a requester
//   ISSUE | RAM strobe for the granted access
//   WAIT  | read latency beyond the first cycle
//   DONE  | read data valid; complete toward the granted side
module blinker_nios2_proc_ocimem_arbiter
  import blinker_nios2_proc_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_busy,
  output logic              jtag_done,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (!ram_lat_ok(RAM_LAT)) begin : g_bad_ram_lat
    $error("RAM_LAT must be within 1..3");
  end

  localparam logic [1:0] WAIT_LOAD = (RAM_LAT > 1) ? 2'(RAM_LAT - 2) : 2'd0;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
  logic              acc_wr_q, acc_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] jtag_rdata_q, jtag_rdata_d;
  logic              jtag_done_q, jtag_done_d;
  logic              overrun_q, overrun_d;

  logic avs_req;
  logic pick;
  logic pick_valid;
  logic take_jtag;

  assign avs_req = avs_read | avs_write;

  blinker_nios2_proc_ocimem_rr2 u_rr2 (
    .req         ({avs_req, pend_q}),
    .last_grant  (last_grant_q),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pend_d       = pend_q;
    pend_wr_d    = pend_wr_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    acc_wr_d     = acc_wr_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    cnt_d        = cnt_q;
    jtag_rdata_d = jtag_rdata_q;
    jtag_done_d  = 1'b0;
    overrun_d    = overrun_q;
    take_jtag    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d      = pick;
          last_grant_d = pick;
          state_d      = ST_ISSUE;
          if (pick == GRANT_JTAG) begin
            take_jtag   = 1'b1;
            acc_wr_d    = pend_wr_q;
            ram_addr_d  = pend_addr_q;
            ram_wdata_d = pend_wdata_q;
          end else begin
            // both strobes high is a write
            acc_wr_d    = avs_write;
            ram_addr_d  = avs_address;
            ram_wdata_d = avs_writedata;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = WAIT_LOAD;
        state_d = (acc_wr_q || RAM_LAT == 1) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (grant_q == GRANT_JTAG) begin
          jtag_done_d = 1'b1;
          if (!acc_wr_q) jtag_rdata_d = ram_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pending frees up as it is granted, so a request in that cycle is kept.
    if (take_jtag) pend_d = 1'b0;
    if (jtag_req) begin
      if (pend_q && !take_jtag) begin
        overrun_d = 1'b1;
      end else begin
        pend_d       = 1'b1;
        pend_wr_d    = jtag_wr;
        pend_addr_d  = jtag_addr;
        pend_wdata_d = jtag_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= GRANT_AVS;
      last_grant_q <= GRANT_AVS;
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      acc_wr_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cnt_q        <= '0;
      jtag_rdata_q <= '0;
      jtag_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      pend_wr_q    <= pend_wr_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      acc_wr_q     <= acc_wr_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cnt_q        <= cnt_d;
      jtag_rdata_q <= jtag_rdata_d;
      jtag_done_q  <= jtag_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Strobes decode from state so a reset in ISSUE kills the write at once.
  assign ram_en    = (state_q == ST_ISSUE);
  assign ram_wr    = ram_en & acc_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  assign avs_readdata    = ram_rdata;
  assign avs_waitrequest = avs_req & ~((state_q == ST_DONE) && (grant_q == GRANT_AVS));

  assign jtag_rdata   = jtag_rdata_q;
  assign jtag_done    = jtag_done_q;
  assign jtag_overrun = overrun_q;
  assign jtag_busy    = pend_q | ((grant_q == GRANT_JTAG) && (state_q != ST_IDLE)) | jtag_done_q;

endmodule

// File: tb/tb_blinker_nios2_proc_ocimem_arbiter.sv
// Bench for the OCI memory arbiter: two instances (RAM_LAT 1 and 3), each
// with its own RAM model, checked against a shadow memory and latency rules.
module tb_blinker_nios2_proc_ocimem_arbiter;

  logic        clk;
  logic        rst             [2];
  logic        jtag_req        [2];
  logic        jtag_wr         [2];
  logic [7:0]  jtag_addr       [2];
  logic [31:0] jtag_wdata      [2];
  logic        jtag_busy       [2];
  logic        jtag_done       [2];
  logic [31:0] jtag_rdata      [2];
  logic        jtag_overrun    [2];
  logic [7:0]  avs_address     [2];
  logic        avs_read        [2];
  logic        avs_write       [2];
  logic [31:0] avs_writedata   [2];
  logic [31:0] avs_readdata    [2];
  logic        avs_waitrequest [2];
  logic        ram_en          [2];
  logic        ram_wr          [2];
  logic [7:0]  ram_addr        [2];
  logic [31:0] ram_wdata       [2];
  logic [31:0] ram_rdata       [2];

  logic [31:0] ram_mem [2][256];
  logic [31:0] rd_pipe [2][3];
  logic [31:0] shadow  [2][256];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    blinker_nios2_proc_ocimem_arbiter #(
      .ADDR_W(8), .DATA_W(32), .RAM_LAT((g == 0) ? 1 : 3)
    ) u_dut (
      .clk             (clk),
      .reset           (rst[g]),
      .jtag_req        (jtag_req[g]),
      .jtag_wr         (jtag_wr[g]),
      .jtag_addr       (jtag_addr[g]),
      .jtag_wdata      (jtag_wdata[g]),
      .jtag_busy       (jtag_busy[g]),
      .jtag_done       (jtag_done[g]),
      .jtag_rdata      (jtag_rdata[g]),
      .jtag_overrun    (jtag_overrun[g]),
      .avs_address     (avs_address[g]),
      .avs_read        (avs_read[g]),
      .avs_write       (avs_write[g]),
      .avs_writedata   (avs_writedata[g]),
      .avs_readdata    (avs_readdata[g]),
      .avs_waitrequest (avs_waitrequest[g]),
      .ram_en          (ram_en[g]),
      .ram_wr          (ram_wr[g]),
      .ram_addr        (ram_addr[g]),
      .ram_wdata       (ram_wdata[g]),
      .ram_rdata       (ram_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data appears RAM_LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_en[i] && ram_wr[i]) ram_mem[i][ram_addr[i]] <= ram_wdata[i];
      rd_pipe[i][0] <= ram_en[i] ? ram_mem[i][ram_addr[i]] : 32'hBAD0BAD0;
      rd_pipe[i][1] <= rd_pipe[i][0];
      rd_pipe[i][2] <= rd_pipe[i][1];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) ram_rdata[i] = rd_pipe[i][lat_of(i) - 1];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    #1;
    tick();
    tick();
    rst[i] = 1'b0;
    tick();
  endtask

  task automatic jtag_op(input int i, input logic wr, input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int cyc, output int ens);
    jtag_req[i] = 1'b1; jtag_wr[i] = wr; jtag_addr[i] = a; jtag_wdata[i] = d;
    tick();
    jtag_req[i] = 1'b0;
    #1;
    chk1("jtag_busy_pending", jtag_busy[i], 1'b1);
    cyc = 1;
    ens = 0;
    while (!jtag_done[i] && cyc < 40) begin
      if (ram_en[i]) ens++;
      tick();
      cyc++;
    end
    rd = jtag_rdata[i];
  endtask

  task automatic avs_op(input int i, input logic wr, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int cyc);
    avs_address[i] = a; avs_writedata[i] = d; avs_write[i] = wr; avs_read[i] = !wr;
    #1;
    cyc = 0;
    while (avs_waitrequest[i] && cyc < 40) begin
      tick();
      cyc++;
    end
    rd = avs_readdata[i];
    tick();
    avs_read[i] = 1'b0; avs_write[i] = 1'b0;
    #1;
  endtask

  // JTAG write pulse, then an Avalon write competing in the next IDLE cycle.
  task automatic tie_run(input int i, input logic [7:0] aa, input logic [7:0] ja,
                         output logic [7:0] first, output logic [7:0] second);
    int n;
    bit avs_fin, j_fin;
    n = 0; avs_fin = 0; j_fin = 0; first = 8'h00; second = 8'h00;
    jtag_req[i] = 1'b1; jtag_wr[i] = 1'b1; jtag_addr[i] = ja; jtag_wdata[i] = {24'h0, ja};
    tick();
    jtag_req[i] = 1'b0;
    avs_write[i] = 1'b1; avs_address[i] = aa; avs_writedata[i] = {24'h0, aa};
    #1;
    for (int k = 0; k < 30 && !(avs_fin && j_fin); k++) begin
      if (ram_en[i]) begin
        if (n == 0) first = ram_addr[i];
        else if (n == 1) second = ram_addr[i];
        n++;
      end
      if (jtag_done[i]) j_fin = 1;
      if (avs_write[i] && !avs_waitrequest[i]) begin
        tick();
        avs_write[i] = 1'b0;
        avs_fin = 1;
        #1;
      end else begin
        tick();
      end
    end
    chk("tie_access_count", 32'(n), 32'd2);
    shadow[i][ja] = {24'h0, ja};
    shadow[i][aa] = {24'h0, aa};
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time %0t reached without summary, required finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [31:0] rd;
    logic [7:0]  f, s;
    int cyc, ens, pulses;

    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 8'h11, 32'h0,        32'hC0DE0011};
    vecs[3] = '{1'b1, 8'hFF, 32'h12345678, 32'hC0DE0011};
    vecs[4] = '{1'b0, 8'hFF, 32'h0,        32'h12345678};
    vecs[5] = '{1'b0, 8'h00, 32'h0,        32'hC0DE0000};

    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) begin
        ram_mem[i][a] = init_word(a);
        shadow[i][a]  = init_word(a);
      end
      for (int k = 0; k < 3; k++) rd_pipe[i][k] = 32'h0;
      rst[i] = 1'b1; jtag_req[i] = 1'b0; jtag_wr[i] = 1'b0; jtag_addr[i] = 8'h0;
      jtag_wdata[i] = 32'h0; avs_address[i] = 8'h0; avs_read[i] = 1'b0;
      avs_write[i] = 1'b0; avs_writedata[i] = 32'h0;
    end

    // Reset values, with an Avalon read held on instance 1 during reset.
    avs_read[1] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk1("rst_waitrequest", avs_waitrequest[i], (i == 1));
      chk1("rst_jtag_busy", jtag_busy[i], 1'b0);
      chk1("rst_jtag_done", jtag_done[i], 1'b0);
      chk("rst_jtag_rdata", jtag_rdata[i], 32'h0);
      chk1("rst_overrun", jtag_overrun[i], 1'b0);
      chk1("rst_ram_en", ram_en[i], 1'b0);
      chk1("rst_ram_wr", ram_wr[i], 1'b0);
    end
    avs_read[1] = 1'b0;
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // Table: JTAG write/read sequences on both latencies.
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 6; r++) begin
        jtag_op(i, vecs[r].wr, vecs[r].addr, vecs[r].wdata, rd, cyc, ens);
        chk("tbl_jtag_rdata", rd, vecs[r].exp_rd);
        chk("tbl_jtag_latency", 32'(cyc), vecs[r].wr ? 32'd4 : 32'(3 + lat_of(i)));
        chk("tbl_ram_en_cycles", 32'(ens), 32'd1);
        if (vecs[r].wr) shadow[i][vecs[r].addr] = vecs[r].wdata;
      end
      chk1("tbl_no_overrun", jtag_overrun[i], 1'b0);
    end

    // Avalon read with RAM_LAT=3, cycle by cycle.
    avs_address[1] = 8'h20; avs_read[1] = 1'b1;
    #1;
    for (int c = 0; c <= 4; c++) begin
      chk1("avs3_waitrequest", avs_waitrequest[1], (c != 4));
      chk1("avs3_ram_en", ram_en[1], (c == 1));
      if (c == 1) begin
        chk("avs3_ram_addr", {24'h0, ram_addr[1]}, 32'h20);
        chk1("avs3_ram_wr", ram_wr[1], 1'b0);
      end
      if (c == 4) chk("avs3_readdata", avs_readdata[1], shadow[1][8'h20]);
      if (c != 4) tick();
    end
    tick();
    avs_read[1] = 1'b0;
    #1;

    // Contention: first tie after reset goes to JTAG, later tie after a JTAG grant to Avalon.
    do_reset(0);
    tie_run(0, 8'h30, 8'h31, f, s);
    chk("tie1_first", {24'h0, f}, 32'h31);
    chk("tie1_second", {24'h0, s}, 32'h30);
    jtag_op(0, 1'b1, 8'h32, 32'h32, rd, cyc, ens);
    shadow[0][8'h32] = 32'h32;
    tie_run(0, 8'h33, 8'h34, f, s);
    chk("tie2_first", {24'h0, f}, 32'h33);
    chk("tie2_second", {24'h0, s}, 32'h34);

    // Overrun: second JTAG pulse arrives while the first is still pending.
    avs_address[1] = 8'h40; avs_read[1] = 1'b1;
    tick();
    jtag_req[1] = 1'b1; jtag_wr[1] = 1'b1; jtag_addr[1] = 8'h50; jtag_wdata[1] = 32'hCAFEF00D;
    tick();
    jtag_req[1] = 1'b0;
    tick();
    jtag_req[1] = 1'b1; jtag_wr[1] = 1'b1; jtag_addr[1] = 8'h51; jtag_wdata[1] = 32'h0BAD0BAD;
    tick();
    jtag_req[1] = 1'b0;
    #1;
    chk1("ovr_flag", jtag_overrun[1], 1'b1);
    chk1("ovr_busy", jtag_busy[1], 1'b1);
    chk1("ovr_avs_waitrequest", avs_waitrequest[1], 1'b0);
    chk("ovr_avs_readdata", avs_readdata[1], shadow[1][8'h40]);
    tick();
    avs_read[1] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (jtag_done[1]) pulses++;
      tick();
    end
    chk("ovr_done_pulses", 32'(pulses), 32'd1);
    shadow[1][8'h50] = 32'hCAFEF00D;
    jtag_op(1, 1'b0, 8'h50, 32'h0, rd, cyc, ens);
    chk("ovr_first_written", rd, shadow[1][8'h50]);
    jtag_op(1, 1'b0, 8'h51, 32'h0, rd, cyc, ens);
    chk("ovr_second_dropped", rd, shadow[1][8'h51]);
    chk1("ovr_sticky", jtag_overrun[1], 1'b1);

    // Reset during WAIT on an Avalon read; the held read restarts afterwards.
    avs_address[1] = 8'h60; avs_read[1] = 1'b1;
    tick();
    tick();
    rst[1] = 1'b1;
    #1;
    chk1("rstw_waitrequest", avs_waitrequest[1], 1'b1);
    chk1("rstw_ram_en", ram_en[1], 1'b0);
    chk1("rstw_jtag_done", jtag_done[1], 1'b0);
    chk1("rstw_overrun_cleared", jtag_overrun[1], 1'b0);
    tick();
    chk1("rstw_waitrequest_hold", avs_waitrequest[1], 1'b1);
    rst[1] = 1'b0;
    #1;
    cyc = 0;
    while (avs_waitrequest[1] && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("rstw_restart_latency", 32'(cyc), 32'd4);
    chk("rstw_readdata", avs_readdata[1], shadow[1][8'h60]);
    tick();
    avs_read[1] = 1'b0;
    #1;

    // Reset in the ISSUE cycle of an Avalon write must suppress the write.
    avs_address[0] = 8'h70; avs_writedata[0] = 32'hFFFF0000; avs_write[0] = 1'b1;
    tick();
    chk1("rsti_ram_wr_before", ram_wr[0], 1'b1);
    rst[0] = 1'b1;
    #1;
    chk1("rsti_ram_en", ram_en[0], 1'b0);
    chk1("rsti_ram_wr", ram_wr[0], 1'b0);
    avs_write[0] = 1'b0;
    tick();
    rst[0] = 1'b0;
    tick();
    jtag_op(0, 1'b0, 8'h70, 32'h0, rd, cyc, ens);
    chk("rsti_mem_unchanged", rd, shadow[0][8'h70]);

    // Read and write together count as a write.
    avs_address[0] = 8'h05; avs_writedata[0] = 32'h55AA55AA;
    avs_read[0] = 1'b1; avs_write[0] = 1'b1;
    #1;
    chk1("rw_wait_c0", avs_waitrequest[0], 1'b1);
    tick();
    chk1("rw_ram_en", ram_en[0], 1'b1);
    chk1("rw_ram_wr", ram_wr[0], 1'b1);
    chk("rw_ram_addr", {24'h0, ram_addr[0]}, 32'h05);
    chk("rw_ram_wdata", ram_wdata[0], 32'h55AA55AA);
    chk1("rw_wait_c1", avs_waitrequest[0], 1'b1);
    tick();
    chk1("rw_wait_c2", avs_waitrequest[0], 1'b0);
    tick();
    avs_read[0] = 1'b0; avs_write[0] = 1'b0;
    shadow[0][8'h05] = 32'h55AA55AA;
    jtag_op(0, 1'b0, 8'h05, 32'h0, rd, cyc, ens);
    chk("rw_readback", rd, shadow[0][8'h05]);

    // Random mix of JTAG and Avalon accesses against the shadow memory.
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 60; n++) begin
        logic        is_j, wr;
        logic [7:0]  a;
        logic [31:0] d;
        is_j = 1'($urandom_range(0, 1));
        wr   = 1'($urandom_range(0, 1));
        a    = 8'($urandom_range(0, 255));
        d    = $urandom;
        if (is_j) begin
          jtag_op(i, wr, a, d, rd, cyc, ens);
          chk("rnd_jtag_latency", 32'(cyc), wr ? 32'd4 : 32'(3 + lat_of(i)));
        end else begin
          avs_op(i, wr, a, d, rd, cyc);
          chk("rnd_avs_latency", 32'(cyc), wr ? 32'd2 : 32'(1 + lat_of(i)));
        end
        if (wr) shadow[i][a] = d;
        else chk(is_j ? "rnd_jtag_rdata" : "rnd_avs_rdata", rd, shadow[i][a]);
        repeat ($urandom_range(0, 2)) tick();
      end
      chk1("rnd_no_overrun", jtag_overrun[i], 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
